// File: rtl/vga_cell_framebuffer.sv
// Cell-based (8x8 pixel) RGB333 framebuffer feeding the VGA controller with a fixed
// two-clock read latency, plus a host write port and a full-screen fill engine.
module vga_cell_framebuffer #(
  parameter int CELL_SHIFT = 3,
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int ADDR_W     = 13
) (
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  input  logic [11:0]       i_X,
  input  logic [11:0]       i_Y,
  output logic [2:0]        o_VGA_Red,
  output logic [2:0]        o_VGA_Grn,
  output logic [2:0]        o_VGA_Blu,
  input  logic              i_Wr_DV,
  input  logic [ADDR_W-1:0] i_Wr_Addr,
  input  logic [8:0]        i_Wr_Data,
  output logic              o_Wr_Ready,
  input  logic              i_Clear,
  input  logic [8:0]        i_Clear_Color,
  output logic              o_Busy,
  output logic              o_Clear_Done
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [8:0]        fill_color_q, fill_color_d;
  logic              wr_ready_q, wr_ready_d;

  logic [ADDR_W-1:0] cell_row, cell_col, rd_addr_d, rd_addr_q;
  logic              vis1_d, vis1_q, vis2_q;
  logic [8:0]        rd_data_q;
  logic [8:0]        ram_q [CELLS];

  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [8:0]        ram_wd;

  // row*80 as (row<<6)+(row<<4); blanking coordinates may overflow, vis gates them
  assign cell_row  = ADDR_W'(i_Y >> CELL_SHIFT);
  assign cell_col  = ADDR_W'(i_X >> CELL_SHIFT);
  assign rd_addr_d = (cell_row << 6) + (cell_row << 4) + cell_col;
  assign vis1_d    = (i_X < 12'(H_VISIBLE)) && (i_Y < 12'(V_VISIBLE));

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rd_addr_q <= '0;
      vis1_q    <= 1'b0;
      vis2_q    <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      vis1_q    <= vis1_d;
      vis2_q    <= vis1_q;
    end
  end

  // Single write port shared by the fill engine and host; host is locked out while filling
  always_comb begin
    ram_we = 1'b0;
    ram_wa = i_Wr_Addr;
    ram_wd = i_Wr_Data;
    if (state_q == ST_FILL) begin
      ram_we = 1'b1;
      ram_wa = fill_addr_q;
      ram_wd = fill_color_q;
    end else if (i_Wr_DV && wr_ready_q && (i_Wr_Addr <= LAST_CELL)) begin
      ram_we = 1'b1;
    end
  end

  // Block RAM: no reset, read-first on same-address collisions
  always_ff @(posedge i_Clk) begin
    if (ram_we) begin
      ram_q[ram_wa] <= ram_wd;
    end
    rd_data_q <= ram_q[rd_addr_q];
  end

  assign {o_VGA_Red, o_VGA_Grn, o_VGA_Blu} = vis2_q ? rd_data_q : 9'd0;

  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    fill_color_d = fill_color_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_Clear) begin
          state_d      = ST_FILL;
          fill_addr_d  = '0;
          fill_color_d = i_Clear_Color;
        end
      end
      ST_FILL: begin
        if (fill_addr_q == LAST_CELL) begin
          state_d = ST_DONE;
        end else begin
          fill_addr_d = fill_addr_q + ADDR_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    wr_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= ST_IDLE;
      fill_addr_q  <= '0;
      fill_color_q <= '0;
      wr_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      fill_color_q <= fill_color_d;
      wr_ready_q   <= wr_ready_d;
    end
  end

  assign o_Wr_Ready   = wr_ready_q;
  assign o_Busy       = (state_q == ST_FILL);
  assign o_Clear_Done = (state_q == ST_DONE);

endmodule
